mac_acc_seq: RTL and testbench
==============================

Name: mac_acc_seq

Overview:
- Sequential, parametrised multiply-accumulate engine for the CNN datapath.
- Consumes a stream of signed fixed-point (activation, weight) pairs over a valid/ready handshake and accumulates exactly LEN products per window (e.g. one 3x3 kernel).
- At the end of each window it adds a per-window bias, then rounds, rescales, saturates and optionally applies ReLU.
- Emits one DATA_W result per window over a valid/ready output handshake. It is the per-output compute element used by the convolution and dense layer controllers.

Parameters:
- DATA_W, 16, width of activation, weight, bias and result (signed two's complement).
- FRAC_W, 8, fractional bits of all DATA_W quantities (Q(DATA_W-FRAC_W).FRAC_W). Legal range 1 to DATA_W-1.
- LEN, 9, products per window. Must be at least 1.
- ACC_W, 40, accumulator width. Must satisfy ACC_W >= 2*DATA_W + clog2(LEN) + 1 (elaboration-time check).
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  engine can accept a pair.
- in_data  in  DATA_W  signed activation.
- in_w  in  DATA_W  signed weight.
- in_bias  in  DATA_W  signed bias, sampled only on the first beat of a window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed, rounded, saturated result.
- out_ovf  out  1  saturation occurred for this result; qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: in_ready=0 while rst_n=0, then 1 in the first cycle after release. out_valid=0, out_data=0, out_ovf=0. Beat counter=0, accumulator=0, pipeline valids=0.
- A beat transfers when in_valid & in_ready are both high at a rising edge. An output transfers when out_valid & out_ready are both high.
- FSM states:
  - ACC: in_ready=1. Count beats 0..LEN-1. The LEN-th beat moves to DRAIN.
  - DRAIN: in_ready=0. Wait for the last product to reach the accumulator, 1 cycle, then go to FIN.
  - FIN: in_ready=0. Register the finalised result, set out_valid=1, go to OUT.
  - OUT: in_ready=0. Hold out_data and out_ovf stable while out_ready=0. On the output handshake, clear out_valid and go to ACC.
- Pipeline: stage 1 registers the product in_data*in_w (2*DATA_W, signed). Stage 2 sign-extends it to ACC_W and accumulates.
  - The first beat's product loads the accumulator instead of adding to it. No explicit clear is needed.
  - in_bias is registered on the first beat.
- Latency: the last beat handshakes in cycle N; out_valid=1 in cycle N+3, independent of gaps in in_valid earlier in the window.
- Gaps: in_valid may drop at any point in ACC. The counter advances only on handshakes.
- Finalise:
  - s = acc + (sign_ext(bias) << FRAC_W) + (1 << (FRAC_W-1)).
  - r = s >>> FRAC_W (arithmetic shift; round half up).
  - If r > 2^(DATA_W-1)-1, the result is 0x7FF..F and out_ovf=1. If r < -2^(DATA_W-1), the result is 0x800..0 and out_ovf=1. Otherwise the result is r[DATA_W-1:0] and out_ovf=0.
  - If RELU_EN=1 and the result is negative, out_data=0. out_ovf still reports a negative saturation.
- No overlap: the next window cannot begin until the output handshake. The earliest first beat of the next window is the cycle after the handshake.
- LEN=1: the first beat is also the last beat; go directly to DRAIN.
- Reset mid-operation (any state) discards the partial window or pending result and returns to the reset values.
- The accumulator never wraps within the legal ACC_W range.

Decomposition:
- Package mac_pkg: FSM state enum (ACC, DRAIN, FIN, OUT), clog2-derived counter width, and saturation constants as functions of DATA_W.
- Sub-module mac_round_sat: combinational; takes ACC_W acc and DATA_W bias, produces out_data and out_ovf per the Finalise rules, including ReLU. It is instantiated once in the FIN stage.

Test Plan (DATA_W=16, FRAC_W=8, LEN=9 unless stated):
- Basic: 9 beats back-to-back, in_data=0x0100, in_w=0x0100, in_bias=0x0080 -> out_data=0x0980, out_ovf=0, out_valid rises 3 cycles after the 9th handshake.
- Saturation: 9 beats of in_data=0x7FFF, in_w=0x7FFF, bias=0 -> out_data=0x7FFF, out_ovf=1. in_data=0x8000, in_w=0x7FFF with RELU_EN=0 -> 0x8000, out_ovf=1.
- ReLU and sign: in_data=0x0100, in_w=0xFF00, bias=0 -> RELU_EN=1 gives 0x0000; RELU_EN=0 gives 0xF700; out_ovf=0 in both.
- Backpressure and gaps: in_valid toggling every other cycle on the Basic window, then out_ready held low 5 cycles -> 0x0980 held stable, in_ready=0 throughout, a new window is accepted only from the cycle after the handshake.
- Reset mid-window: 4 Basic beats, rst_n=0 for 1 cycle, then a fresh Basic window -> single result 0x0980, no spurious out_valid.
- Rounding and LEN=1: LEN=1, in_data=0x0180, in_w=0x0101, bias=0 -> 0x0182 (0x018180 + 0x80 = 0x018200, shifted right 8), out_valid 3 cycles after the single beat.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multiply-accumulate engine.
package mac_pkg;

  // Window sequencing states.
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FIN   = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_e;

  // Beat counter width; at least one bit so LEN=1 still has a legal vector.
  function automatic int cnt_width(input int len);
    if (len > 1) begin
      return $clog2(len);
    end else begin
      return 1;
    end
  endfunction

  // Largest representable signed DATA_W value.
  function automatic longint sat_max(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  // Smallest representable signed DATA_W value.
  function automatic longint sat_min(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/mac_acc_seq_if.sv
// Input-pair and result handshakes of the MAC engine.
interface mac_acc_seq_if #(
  parameter int DATA_W = 16
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] in_w;
  logic signed [DATA_W-1:0] in_bias;
  logic                     out_valid;
  logic                     out_ready;
  logic        [DATA_W-1:0] out_data;
  logic                     out_ovf;

  // Producer/consumer side driving pairs and accepting results.
  modport master (
    output in_valid, in_data, in_w, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, in_w, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/mac_round_sat.sv
// Finalises an accumulated window: bias add, round half up, rescale,
// saturate to DATA_W and optional ReLU.
module mac_round_sat
  import mac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 40,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_ovf
);

  // Two guard bits keep the bias/round additions from ever wrapping.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(sat_max(DATA_W));
  localparam logic signed [SW-1:0] SAT_MIN = SW'(sat_min(DATA_W));
  localparam logic signed [SW-1:0] HALF    = SW'(64'sd1 <<< (FRAC_W - 1));

  logic signed [SW-1:0]     acc_ext_s;
  logic signed [SW-1:0]     bias_sh_s;
  logic signed [SW-1:0]     sum_s;
  logic signed [SW-1:0]     r_s;
  logic        [DATA_W-1:0] sat_s;

  assign acc_ext_s = {{2{acc[ACC_W-1]}}, acc};
  assign bias_sh_s = {{(SW-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;
  assign sum_s     = acc_ext_s + bias_sh_s + HALF;
  assign r_s       = sum_s >>> FRAC_W;

  // Clamp the rescaled value into DATA_W and flag any clamp.
  always_comb begin
    sat_s   = r_s[DATA_W-1:0];
    out_ovf = 1'b0;
    if (r_s > SAT_MAX) begin
      sat_s   = SAT_MAX[DATA_W-1:0];
      out_ovf = 1'b1;
    end else if (r_s < SAT_MIN) begin
      sat_s   = SAT_MIN[DATA_W-1:0];
      out_ovf = 1'b1;
    end else begin
      sat_s   = r_s[DATA_W-1:0];
      out_ovf = 1'b0;
    end
  end

  // ReLU zeroes negative results; the overflow flag is left untouched.
  always_comb begin
    out_data = sat_s;
    if (RELU_EN && sat_s[DATA_W-1]) begin
      out_data = {DATA_W{1'b0}};
    end else begin
      out_data = sat_s;
    end
  end

endmodule

// File: rtl/mac_acc_seq.sv
// Sequential multiply-accumulate engine: LEN signed products per window,
// then bias/round/saturate/ReLU and a single registered result.
module mac_acc_seq
  import mac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int LEN     = 9,
  parameter int ACC_W   = 40,
  parameter bit RELU_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mac_acc_seq_if.slave bus
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = cnt_width(LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

  if (LEN < 1) begin : g_len_chk
    $error("mac_acc_seq: LEN must be at least 1");
  end
  if (FRAC_W < 1 || FRAC_W > DATA_W - 1) begin : g_frac_chk
    $error("mac_acc_seq: FRAC_W must be in 1..DATA_W-1");
  end
  if (ACC_W < 2 * DATA_W + $clog2(LEN) + 1) begin : g_acc_chk
    $error("mac_acc_seq: ACC_W too narrow for LEN products");
  end

  mac_state_e               state_r;
  mac_state_e               state_s;
  logic [CW-1:0]            cnt_r;
  logic                     beat_s;
  logic                     last_s;
  logic                     in_ready_r;
  logic signed [PW-1:0]     prod_r;
  logic                     pv_r;
  logic                     pfirst_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [DATA_W-1:0] bias_r;
  logic        [DATA_W-1:0] fin_data_s;
  logic                     fin_ovf_s;
  logic                     out_valid_r;
  logic        [DATA_W-1:0] out_data_r;
  logic                     out_ovf_r;

  assign beat_s        = bus.in_valid & in_ready_r;
  assign last_s        = (cnt_r == LAST_CNT);
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ovf   = out_ovf_r;

  // Next-state selection for the window sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ACC: begin
        if (beat_s && last_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DRAIN: state_s = ST_FIN;
      ST_FIN:   state_s = ST_OUT;
      ST_OUT: begin
        if (bus.out_ready) begin
          state_s = ST_ACC;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_ACC;
    endcase
  end

  // State register, beat counter and registered in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_ACC;
      cnt_r      <= {CW{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == ST_ACC);
      if (beat_s) begin
        if (last_s) begin
          cnt_r <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  // Stage 1: register the product and capture bias on the first beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_r   <= {PW{1'b0}};
      pv_r     <= 1'b0;
      pfirst_r <= 1'b0;
      bias_r   <= {DATA_W{1'b0}};
    end else begin
      pv_r <= beat_s;
      if (beat_s) begin
        prod_r   <= bus.in_data * bus.in_w;
        pfirst_r <= (cnt_r == {CW{1'b0}});
        if (cnt_r == {CW{1'b0}}) begin
          bias_r <= bus.in_bias;
        end
      end
    end
  end

  // Stage 2: first product of a window loads, later products add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (pv_r) begin
      if (pfirst_r) begin
        acc_r <= {{(ACC_W-PW){prod_r[PW-1]}}, prod_r};
      end else begin
        acc_r <= acc_r + {{(ACC_W-PW){prod_r[PW-1]}}, prod_r};
      end
    end
  end

  mac_round_sat #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .ACC_W   (ACC_W),
    .RELU_EN (RELU_EN)
  ) u_round_sat (
    .acc      (acc_r),
    .bias     (bias_r),
    .out_data (fin_data_s),
    .out_ovf  (fin_ovf_s)
  );

  // Result register: load in FIN, hold until the output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else if (state_r == ST_FIN) begin
      out_valid_r <= 1'b1;
      out_data_r  <= fin_data_s;
      out_ovf_r   <= fin_ovf_s;
    end else if (state_r == ST_OUT && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Directed self-checking bench for mac_acc_seq: three instances
// (ReLU LEN=9, signed LEN=9, ReLU LEN=1) sharing one stimulus bus.
module tb_mac_acc_seq;

  logic        clk;
  logic        rst_n;
  logic        valid_s;
  logic [15:0] din_s;
  logic [15:0] win_s;
  logic [15:0] bin_s;
  logic        oready_s;
  int          sel;
  int          checks;
  int          failures;

  mac_acc_seq_if #(.DATA_W(16)) ifa ();
  mac_acc_seq_if #(.DATA_W(16)) ifb ();
  mac_acc_seq_if #(.DATA_W(16)) ifc ();

  assign ifa.in_valid  = valid_s && (sel == 0);
  assign ifb.in_valid  = valid_s && (sel == 1);
  assign ifc.in_valid  = valid_s && (sel == 2);
  assign ifa.in_data   = din_s;
  assign ifb.in_data   = din_s;
  assign ifc.in_data   = din_s;
  assign ifa.in_w      = win_s;
  assign ifb.in_w      = win_s;
  assign ifc.in_w      = win_s;
  assign ifa.in_bias   = bin_s;
  assign ifb.in_bias   = bin_s;
  assign ifc.in_bias   = bin_s;
  assign ifa.out_ready = oready_s && (sel == 0);
  assign ifb.out_ready = oready_s && (sel == 1);
  assign ifc.out_ready = oready_s && (sel == 2);

  mac_acc_seq #(.DATA_W(16), .FRAC_W(8), .LEN(9), .ACC_W(40), .RELU_EN(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mac_acc_seq #(.DATA_W(16), .FRAC_W(8), .LEN(9), .ACC_W(40), .RELU_EN(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  mac_acc_seq #(.DATA_W(16), .FRAC_W(8), .LEN(1), .ACC_W(40), .RELU_EN(1'b1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdy();
    case (sel)
      0: return 32'(ifa.in_ready);
      1: return 32'(ifb.in_ready);
      default: return 32'(ifc.in_ready);
    endcase
  endfunction

  function automatic logic [31:0] ov();
    case (sel)
      0: return 32'(ifa.out_valid);
      1: return 32'(ifb.out_valid);
      default: return 32'(ifc.out_valid);
    endcase
  endfunction

  function automatic logic [31:0] od();
    case (sel)
      0: return 32'(ifa.out_data);
      1: return 32'(ifb.out_data);
      default: return 32'(ifc.out_data);
    endcase
  endfunction

  function automatic logic [31:0] of();
    case (sel)
      0: return 32'(ifa.out_ovf);
      1: return 32'(ifb.out_ovf);
      default: return 32'(ifc.out_ovf);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive n beats; bias is meaningful only on beat 0, later beats carry junk.
  task automatic beats(input string tag, input int n, input logic [15:0] d,
                       input logic [15:0] w, input logic [15:0] b, input bit gap);
    int spur;
    int tmo;
    int t;
    spur = 0;
    tmo  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_s = 1'b1;
      din_s   = d;
      win_s   = w;
      bin_s   = (i == 0) ? b : 16'h7FFF;
      t = 0;
      while (rdy() != 32'd1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) tmo++;
      @(posedge clk);
      #1;
      valid_s = 1'b0;
      if (i < n - 1 && ov() == 32'd1) spur++;
      if (gap && i < n - 1) @(posedge clk);
    end
    chk({tag, "_beat_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_spurious_valid"}, 32'(spur), 32'd0);
  endtask

  // Count edges from the last handshake until out_valid rises.
  task automatic latency(input string tag);
    int edges;
    chk({tag, "_in_ready_low"}, rdy(), 32'd0);
    edges = 0;
    while (ov() != 32'd1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'd2);
  endtask

  task automatic result(input string tag, input logic [15:0] d, input logic o);
    chk({tag, "_data"}, od(), 32'(d));
    chk({tag, "_ovf"}, of(), 32'(o));
    @(negedge clk);
    oready_s = 1'b1;
    @(posedge clk);
    #1;
    oready_s = 1'b0;
    chk({tag, "_valid_clear"}, ov(), 32'd0);
  endtask

  initial begin
    bit stable;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    valid_s  = 1'b0;
    din_s    = 16'h0000;
    win_s    = 16'h0000;
    bin_s    = 16'h0000;
    oready_s = 1'b0;
    sel      = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", rdy(), 32'd0);
    chk("rst_out_valid", ov(), 32'd0);
    chk("rst_out_data", od(), 32'd0);
    chk("rst_out_ovf", of(), 32'd0);
    chk("rst_b_out_valid", 32'(ifb.out_valid), 32'd0);
    chk("rst_c_out_valid", 32'(ifc.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", rdy(), 32'd1);

    // Basic window: 9 * 1.0*1.0 + 0.5 = 9.5.
    beats("basic", 9, 16'h0100, 16'h0100, 16'h0080, 1'b0);
    latency("basic");
    result("basic", 16'h0980, 1'b0);

    // Positive saturation.
    beats("satp", 9, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0);
    latency("satp");
    result("satp", 16'h7FFF, 1'b1);

    // Negative saturation with ReLU: zeroed, overflow still reported.
    beats("satn_relu", 9, 16'h8000, 16'h7FFF, 16'h0000, 1'b0);
    latency("satn_relu");
    result("satn_relu", 16'h0000, 1'b1);

    // Negative result, ReLU on: -9.0 clamps to zero.
    beats("relu", 9, 16'h0100, 16'hFF00, 16'h0000, 1'b0);
    latency("relu");
    result("relu", 16'h0000, 1'b0);

    // Signed instance: negative saturation and plain negative result.
    sel = 1;
    beats("satn", 9, 16'h8000, 16'h7FFF, 16'h0000, 1'b0);
    latency("satn");
    result("satn", 16'h8000, 1'b1);
    beats("neg", 9, 16'h0100, 16'hFF00, 16'h0000, 1'b0);
    latency("neg");
    result("neg", 16'hF700, 1'b0);

    // Gaps on every other cycle, then 5 cycles of backpressure while a
    // stray pair is offered; it must not be taken before the handshake.
    sel = 0;
    beats("gap", 9, 16'h0100, 16'h0100, 16'h0080, 1'b1);
    latency("gap");
    @(negedge clk);
    valid_s = 1'b1;
    din_s   = 16'h7FFF;
    win_s   = 16'h7FFF;
    bin_s   = 16'h7FFF;
    stable  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (ov() != 32'd1 || od() != 32'h0980 || rdy() != 32'd0) stable = 1'b0;
    end
    chk("bp_hold", 32'(stable), 32'd1);
    result("bp", 16'h0980, 1'b0);
    valid_s = 1'b0;
    chk("bp_ready_after_hs", rdy(), 32'd1);
    beats("post_bp", 9, 16'h0100, 16'h0100, 16'h0080, 1'b0);
    latency("post_bp");
    result("post_bp", 16'h0980, 1'b0);

    // Reset in the middle of a window discards the partial sum.
    beats("partial", 4, 16'h0100, 16'h0100, 16'h0080, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", rdy(), 32'd0);
    chk("midrst_out_valid", ov(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beats("after_rst", 9, 16'h0100, 16'h0100, 16'h0080, 1'b0);
    latency("after_rst");
    result("after_rst", 16'h0980, 1'b0);

    // LEN=1: 1.5 * 1.00390625 = 1.505859375 rounds to 0x0182.
    sel = 2;
    beats("len1", 1, 16'h0180, 16'h0101, 16'h0000, 1'b0);
    latency("len1");
    result("len1", 16'h0182, 1'b0);
    // LEN=1: -1.0 * 0.5 + 1.0 = 0.5.
    beats("len1b", 1, 16'hFF00, 16'h0080, 16'h0100, 1'b0);
    latency("len1b");
    result("len1b", 16'h0080, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
